// File: rtl/filter_spad_pkg.sv
// Shared constants for the filter scratchpad and the PE controllers.
package filter_spad_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StLoad  = 2'd1,
        StReady = 2'd2
    } state_e;

endpackage

// File: rtl/filter_spad_if.sv
// Load/read bus between the filter controllers, the PE MAC and the scratchpad.
interface filter_spad_if #(
    parameter int unsigned DATA_W = filter_spad_pkg::DATA_W_DEF,
    parameter int unsigned ADDR_W = filter_spad_pkg::ADDR_W_DEF
);
    logic [ADDR_W:0]   filter_size;
    logic [DATA_W-1:0] din;
    logic              wen;
    logic              co;
    logic              clear;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              last_tap;
    logic              ready;
    logic              ovf_err;

    modport master (
        output filter_size, din, wen, clear, rd_en,
        input  co, dout, dout_valid, last_tap, ready, ovf_err
    );

    modport slave (
        input  filter_size, din, wen, clear, rd_en,
        output co, dout, dout_valid, last_tap, ready, ovf_err
    );
endinterface

// File: rtl/mod_counter.sv
// Modulo counter: counts 0..limit and wraps; clr has priority over inc.
module mod_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    logic [W-1:0] cnt_q, cnt_d;

    assign wrap = inc && (cnt_q == limit);
    assign cnt  = cnt_q;

    // Next count
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/filter_spad.sv
// Filter scratchpad: loads one filter, then replays its taps to the PE MAC.
module filter_spad
    import filter_spad_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input logic           clk,
    input logic           rst,
    filter_spad_if.slave  bus
);
    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] OneW   = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   size_q, size_sel, eff, eff_m1;
    logic [ADDR_W-1:0] wptr, rptr;
    logic              wr_fire, rd_fire, ovf_set, w_wrap, r_wrap, is_last;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout_q;
    logic              dv_q, lt_q, ovf_q;

    // Effective tap count: live size until the first write latches it
    always_comb begin
        size_sel = (state_q == StEmpty) ? bus.filter_size : size_q;
        eff      = (size_sel == '0 || size_sel > DepthW) ? DepthW : size_sel;
        eff_m1   = eff - OneW;
        is_last  = ({1'b0, wptr} == eff_m1);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; the write pointer wrap marks the final tap being written
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: if (wr_fire) state_d = w_wrap ? StReady : StLoad;
                StLoad:  if (w_wrap) state_d = StReady;
                StReady: state_d = StReady;
                default: state_d = StEmpty;
            endcase
        end
    end

    // State-decoded strobes; clear suppresses any write or read that cycle
    always_comb begin
        wr_fire   = 1'b0;
        rd_fire   = 1'b0;
        ovf_set   = 1'b0;
        bus.co    = 1'b0;
        bus.ready = (state_q == StReady);
        case (state_q)
            StEmpty, StLoad: begin
                bus.co  = is_last;
                wr_fire = bus.wen && !bus.clear;
            end
            StReady: begin
                ovf_set = bus.wen && !bus.clear;
                rd_fire = bus.rd_en && !bus.clear;
            end
            default: ;
        endcase
    end

    mod_counter #(.W(ADDR_W)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.clear),
        .inc   (wr_fire),
        .limit (eff_m1[ADDR_W-1:0]),
        .cnt   (wptr),
        .wrap  (w_wrap)
    );

    mod_counter #(.W(ADDR_W)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.clear),
        .inc   (rd_fire),
        .limit (eff_m1[ADDR_W-1:0]),
        .cnt   (rptr),
        .wrap  (r_wrap)
    );

    // Latch the requested size on the first write of a load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_q <= '0;
        end else if (bus.clear) begin
            size_q <= '0;
        end else if (state_q == StEmpty && wr_fire) begin
            size_q <= bus.filter_size;
        end
    end

    // Tap storage; intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wptr] <= bus.din;
        end
    end

    // Registered read port and status flags; dout holds between reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
            dv_q   <= 1'b0;
            lt_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (bus.clear) begin
            dv_q   <= 1'b0;
            lt_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            dv_q <= rd_fire;
            lt_q <= r_wrap;
            if (rd_fire) begin
                dout_q <= mem[rptr];
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.last_tap   = lt_q;
    assign bus.ovf_err    = ovf_q;
endmodule
